w0_refresh_ctrl: RTL and testbench
==================================

# w0_refresh_ctrl

Sequencer for the primary-path W0 coefficient refresh. It waits for the first primary-path sample, then sweeps every W0 tap index. For each index it reads the matching coefficient from the adaptive W filter's read port and presents it to the coefficient quantizer. It then issues the tap index to W0, delayed so that it lines up with the quantizer output. It sits between the W filter read port, the QNS2 modulator and W0's update port, and replaces the free-running index counter with an explicitly staged, drain-aware sweep.

## Interface
Parameters:
- W0_N, 512, number of W0 taps swept per pass
- W_N, 16, number of adaptive W taps
- RATIO_SHIFT, 5, log2(W0_N/W_N) used in index mapping
- COEFF_W, 16, width of W coefficient
- RD_LAT, 1, cycles from rd_idx_out to valid rd_coeff_in (0..3)
- Q_LAT, 1, quantizer latency from q_valid_out to its output (0..7)
- GAP_W, 16, width of inter-sweep gap count

Ports:
- clock, in, 1, system clock
- reset, in, 1, synchronous active-high reset
- up_valid_in, in, 1, primary-path sample valid; first assertion marks boot
- freeze_in, in, 1, inhibit start of new sweeps
- gap_cycles_in, in, GAP_W, idle cycles between sweeps
- rd_idx_out, out, $clog2(W_N), W filter coefficient read index
- rd_coeff_in, in signed, COEFF_W, W filter coefficient, RD_LAT after rd_idx_out
- q_valid_out, out, 1, coefficient valid toward quantizer
- q_coeff_out, out signed, COEFF_W, coefficient toward quantizer
- w0_valid_out, out, 1, W0 update strobe (aligned with quantizer output)
- w0_idx_out, out, $clog2(W0_N), W0 tap being updated
- bootup_done_out, out, 1, sticky boot flag
- busy_out, out, 1, high in SWEEP or DRAIN
- sweep_done_out, out, 1, one-cycle pulse at end of each sweep

## Operation
- Reset value of all outputs is 0. bootup_done_out clears; state goes to IDLE.
- bootup_done_out sets on the cycle after the first up_valid_in=1 and holds until reset.
- States:
  - IDLE: wait for bootup_done_out=1 and freeze_in=0, then go to SWEEP. Sweep counter k=0.
  - SWEEP: one index issued per cycle, k=0..W0_N-1. After issuing k=W0_N-1, go to DRAIN.
  - DRAIN: lasts exactly RD_LAT+1+Q_LAT cycles. sweep_done_out pulses on the cycle after the last w0_valid_out. Then go to GAP.
  - GAP: count gap_cycles_in, sampled on GAP entry, down to 0. Then return to SWEEP if freeze_in=0, otherwise to IDLE.
  - A gap of 0 spends one cycle in GAP.
- freeze_in does not abort a sweep in progress. A sweep, once started, always completes all W0_N indices.
- Index mapping: rd_idx_out = min((k + 2^(RATIO_SHIFT-1)) >> RATIO_SHIFT, W_N-1). The result saturates and never wraps; k=W0_N-1 maps to W_N-1.
- rd_idx_out holds its last value outside SWEEP.
- q_coeff_out is rd_coeff_in captured RD_LAT cycles after issue and registered. It passes through unchanged (no rounding). q_coeff_out holds between valids.
- w0_idx_out/w0_valid_out are the issue index k and the issue-valid delayed by RD_LAT+1+Q_LAT through a shift pipeline.
- busy_out=1 in SWEEP and DRAIN.

## Timing
- If k is issued at cycle t, then q_valid_out/q_coeff_out are valid at t+RD_LAT+1 and w0_valid_out/w0_idx_out=k at t+RD_LAT+1+Q_LAT.
- Within a sweep, q_valid_out and w0_valid_out are each high for exactly W0_N consecutive cycles.
- Sweep period = 1 (IDLE→SWEEP on first sweep only) + W0_N + (RD_LAT+1+Q_LAT) + max(gap,1).
- Reset mid-operation clears the state, all delay pipelines and bootup within the reset cycle. No stale w0_valid_out appears after reset deasserts.
- up_valid_in after boot has no effect. freeze_in and the end of GAP in the same cycle means freeze wins.

## Configuration
- W0_REFRESH_GAP_EN defined: gap_cycles_in controls the GAP length as above.
- Not defined: gap_cycles_in is ignored and GAP is always exactly one cycle. The port remains present for a stable interface.

## Test plan
- Boot: W0_N=64, W_N=4, RATIO_SHIFT=4, RD_LAT=1, Q_LAT=1, up_valid_in pulse at cycle 10.
  - bootup_done_out=1 at 11.
  - First q_valid_out at 14 (t=12, since IDLE→SWEEP takes one cycle).
  - First w0_valid_out at 15 with w0_idx_out=0.
- Mapping/saturation, same configuration: rd_idx_out is
  - 0 for k=0..7
  - 1 for k=8..23
  - 3 for k=56..63, never 0 at the tail
- Throughput: for each sweep, exactly 64 w0_valid_out pulses with indices 0..63 in order. sweep_done_out pulses once, the cycle after the index-63 strobe.
- Gap: gap_cycles_in=5 with macro defined gives 5 idle cycles between sweeps. With the macro undefined, the gap is 1 cycle regardless of gap_cycles_in.
- Freeze: assert freeze_in at k=20.
  - The sweep finishes through k=63.
  - FSM lands in IDLE and no new sweep starts.
  - Deasserting freeze_in restarts at k=0 next cycle.
- Reset at k=30:
  - All outputs are 0 on the next cycle and stay 0 until a new up_valid_in.
  - Restart begins at k=0 with no leftover w0_valid_out.

Source files
------------

// File: rtl/w0_refresh_ctrl_if.sv
// ---------------------------------------------------------------------------
// w0_refresh_ctrl_if
// Bus bundle between the W0 refresh sequencer and its three neighbours:
// the adaptive W filter read port, the coefficient quantizer, and W0's
// update port.
//
//   rd_idx_out   : W filter coefficient read index      (sequencer -> W)
//   rd_coeff_in  : W filter coefficient, RD_LAT later   (W -> sequencer)
//   q_valid_out  : coefficient valid toward quantizer   (sequencer -> Q)
//   q_coeff_out  : coefficient toward quantizer         (sequencer -> Q)
//   w0_valid_out : W0 update strobe                     (sequencer -> W0)
//   w0_idx_out   : W0 tap being updated                 (sequencer -> W0)
//
// master : the sequencer side; slave : the surrounding datapath side.
// ---------------------------------------------------------------------------
interface w0_refresh_ctrl_if #(
  parameter int W0_N    = 512,
  parameter int W_N     = 16,
  parameter int COEFF_W = 16
);
  logic        [$clog2(W_N)-1:0]  rd_idx_out;
  logic signed [COEFF_W-1:0]      rd_coeff_in;
  logic                           q_valid_out;
  logic signed [COEFF_W-1:0]      q_coeff_out;
  logic                           w0_valid_out;
  logic        [$clog2(W0_N)-1:0] w0_idx_out;

  modport master (
    output rd_idx_out, q_valid_out, q_coeff_out, w0_valid_out, w0_idx_out,
    input  rd_coeff_in
  );

  modport slave (
    input  rd_idx_out, q_valid_out, q_coeff_out, w0_valid_out, w0_idx_out,
    output rd_coeff_in
  );
endinterface

// File: rtl/w0_refresh_ctrl.sv
// ---------------------------------------------------------------------------
// w0_refresh_ctrl
// Sequencer for the primary-path W0 coefficient refresh. After the first
// primary-path sample it sweeps every W0 tap index k = 0..W0_N-1, one per
// cycle. For each k it reads the matching W coefficient, forwards it to the
// quantizer and issues k to W0 delayed to line up with the quantizer output.
// Each sweep is followed by a drain (pipeline flush) and an inter-sweep gap.
//
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   up_valid_in         : primary-path sample valid; first one marks boot
//   freeze_in           : inhibit the start of new sweeps
//   gap_cycles_in       : idle cycles between sweeps (sampled on GAP entry)
//   bootup_done_out     : sticky boot flag
//   busy_out            : high while sweeping or draining
//   sweep_done_out      : one-cycle pulse after the last W0 strobe of a sweep
//   bus (master)        : W read port, quantizer and W0 update signals
//
// Build option: define W0_REFRESH_GAP_EN to let gap_cycles_in set the gap
// length; otherwise the gap is always a single cycle and gap_cycles_in is
// ignored.
// ---------------------------------------------------------------------------
module w0_refresh_ctrl #(
  parameter int W0_N        = 512,
  parameter int W_N         = 16,
  parameter int RATIO_SHIFT = 5,
  parameter int COEFF_W     = 16,
  parameter int RD_LAT      = 1,
  parameter int Q_LAT       = 1,
  parameter int GAP_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_valid_in,
  input  logic             freeze_in,
  input  logic [GAP_W-1:0] gap_cycles_in,
  output logic             bootup_done_out,
  output logic             busy_out,
  output logic             sweep_done_out,
  w0_refresh_ctrl_if.master bus
);

  localparam int W0_IW  = $clog2(W0_N);
  localparam int RD_IW  = $clog2(W_N);
  // Issue-to-W0 alignment: read latency + capture register + quantizer.
  localparam int PIPE_L = RD_LAT + 1 + Q_LAT;
  localparam int CNT_W  = 4;

  localparam logic [W0_IW-1:0] K_LAST     = W0_IW'(W0_N - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_L - 1);
  localparam logic [W0_IW:0]   ROUND_HALF = (W0_IW+1)'((2**RATIO_SHIFT) / 2);
  localparam logic [W0_IW:0]   RD_MAX     = (W0_IW+1)'(W_N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t                     state_q, state_d;
  logic        [W0_IW-1:0]    k_q, k_d;
  logic        [CNT_W-1:0]    drain_q, drain_d;
  logic        [GAP_W-1:0]    gap_q, gap_d;
  logic                       boot_q, boot_d;
  logic                       done_q, done_d;
  logic        [RD_IW-1:0]    rd_idx_q, rd_idx_d;
  logic        [PIPE_L-1:0]   vld_sr_q, vld_sr_d;
  logic        [W0_IW-1:0]    idx_sr_q [PIPE_L];
  logic        [W0_IW-1:0]    idx_sr_d [PIPE_L];
  logic                       q_valid_q, q_valid_d;
  logic signed [COEFF_W-1:0]  q_coeff_q, q_coeff_d;

  logic                       issue_vld;
  logic        [PIPE_L:0]     vld_taps;
  logic                       cap_vld;
  logic        [GAP_W-1:0]    gap_load;

  // Rounded down-mapping from W0 tap index to W tap index. The sum is one
  // bit wider than k so the rounding offset cannot wrap the top indices
  // back to 0; the result is clamped to the last W tap instead.
  function automatic logic [RD_IW-1:0] map_idx(input logic [W0_IW-1:0] k);
    logic [W0_IW:0] sum;
    sum = {1'b0, k} + ROUND_HALF;
    sum = sum >> RATIO_SHIFT;
    if (sum > RD_MAX) begin
      return RD_MAX[RD_IW-1:0];
    end
    return sum[RD_IW-1:0];
  endfunction

`ifdef W0_REFRESH_GAP_EN
  assign gap_load = gap_cycles_in;
`else
  assign gap_load = GAP_W'(1);
  logic unused_gap;
  assign unused_gap = ^gap_cycles_in;
`endif

  // ---- state register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      drain_q   <= '0;
      gap_q     <= '0;
      boot_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_idx_q  <= '0;
      vld_sr_q  <= '0;
      q_valid_q <= 1'b0;
      q_coeff_q <= '0;
      for (int i = 0; i < PIPE_L; i++) begin
        idx_sr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      drain_q   <= drain_d;
      gap_q     <= gap_d;
      boot_q    <= boot_d;
      done_q    <= done_d;
      rd_idx_q  <= rd_idx_d;
      vld_sr_q  <= vld_sr_d;
      q_valid_q <= q_valid_d;
      q_coeff_q <= q_coeff_d;
      for (int i = 0; i < PIPE_L; i++) begin
        idx_sr_q[i] <= idx_sr_d[i];
      end
    end
  end

  // ---- next state ----
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    drain_d  = drain_q;
    gap_d    = gap_q;
    done_d   = 1'b0;
    boot_d   = boot_q | up_valid_in;
    rd_idx_d = rd_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (boot_q && !freeze_in) begin
          state_d = S_SWEEP;
          k_d     = '0;
        end
      end
      // freeze_in is deliberately not looked at here: a started sweep runs
      // to its last index.
      S_SWEEP: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_GAP;
          gap_d   = gap_load;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_GAP: begin
        // A loaded count of 0 or 1 both give one GAP cycle.
        if (gap_q <= GAP_W'(1)) begin
          if (freeze_in) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SWEEP;
            k_d     = '0;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read index follows the index being issued next cycle; holds otherwise.
    if (state_d == S_SWEEP) begin
      rd_idx_d = map_idx(k_d);
    end
  end

  // ---- issue / capture / W0 alignment pipelines ----
  assign issue_vld = (state_q == S_SWEEP);
  // vld_taps[j] is the issue-valid delayed by j cycles.
  assign vld_taps  = {vld_sr_q, issue_vld};
  assign cap_vld   = vld_taps[RD_LAT];

  always_comb begin
    vld_sr_d    = vld_taps[PIPE_L-1:0];
    idx_sr_d[0] = k_q;
    for (int i = 1; i < PIPE_L; i++) begin
      idx_sr_d[i] = idx_sr_q[i-1];
    end
    q_valid_d = cap_vld;
    q_coeff_d = cap_vld ? bus.rd_coeff_in : q_coeff_q;
  end

  assign bus.rd_idx_out   = rd_idx_q;
  assign bus.q_valid_out  = q_valid_q;
  assign bus.q_coeff_out  = q_coeff_q;
  assign bus.w0_valid_out = vld_sr_q[PIPE_L-1];
  assign bus.w0_idx_out   = idx_sr_q[PIPE_L-1];
  assign bootup_done_out  = boot_q;
  assign busy_out         = (state_q == S_SWEEP) || (state_q == S_DRAIN);
  assign sweep_done_out   = done_q;

endmodule

// File: tb/tb_w0_refresh_ctrl.sv
// ---------------------------------------------------------------------------
// tb_w0_refresh_ctrl
// Randomized bench for w0_refresh_ctrl with W0_N=64, W_N=4, RATIO_SHIFT=4,
// RD_LAT=1, Q_LAT=1. A cycle-level reference model tracks the sweep as a
// position within a sweep period and schedules the expected quantizer and
// W0 events in associative arrays keyed by cycle number.
// ---------------------------------------------------------------------------
module tb_w0_refresh_ctrl;
  localparam int W0_N   = 64;
  localparam int W_N    = 4;
  localparam int RS     = 4;
  localparam int CW     = 16;
  localparam int RD_LAT = 1;
  localparam int Q_LAT  = 1;
  localparam int GAP_W  = 16;
  localparam int L      = RD_LAT + 1 + Q_LAT;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             up_valid_in = 1'b0;
  logic             freeze_in = 1'b0;
  logic [GAP_W-1:0] gap_cycles_in = 16'd5;
  logic             bootup_done_out;
  logic             busy_out;
  logic             sweep_done_out;

  w0_refresh_ctrl_if #(.W0_N(W0_N), .W_N(W_N), .COEFF_W(CW)) bus ();

  w0_refresh_ctrl #(
    .W0_N(W0_N), .W_N(W_N), .RATIO_SHIFT(RS), .COEFF_W(CW),
    .RD_LAT(RD_LAT), .Q_LAT(Q_LAT), .GAP_W(GAP_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .up_valid_in     (up_valid_in),
    .freeze_in       (freeze_in),
    .gap_cycles_in   (gap_cycles_in),
    .bootup_done_out (bootup_done_out),
    .busy_out        (busy_out),
    .sweep_done_out  (sweep_done_out),
    .bus             (bus.master)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // W filter read port with one cycle of latency.
  logic [CW-1:0] wmem [W_N];
  always @(posedge clock) bus.rd_coeff_in <= wmem[bus.rd_idx_out];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // ---- reference model ----
  bit            m_boot = 0;
  bit            m_run  = 0;
  int            m_pos  = 0;
  int            m_G    = 1;
  int            m_rd   = 0;
  logic [CW-1:0] m_qc   = '0;
  logic [CW-1:0] exp_q  [int];
  int            exp_w0 [int];

  function automatic int ref_map(input int k);
    int i;
    i = (k + (1 << RS) / 2) / (1 << RS);
    if (i > W_N - 1) i = W_N - 1;
    return i;
  endfunction

  // Directed observations for the boot-latency and gap-length checks.
  bit track = 0;
  int up_cyc = -1, first_boot = -1, first_q = -1, first_w0 = -1;
  bit done_seen = 0, gap_measured = 0;
  int gap_obs = 0;

  task automatic step(input bit rst, input bit uv, input bit frz, input int gap);
    bit issuing;
    @(negedge clock);
    issuing = m_run && (m_pos < W0_N);
    if (issuing) m_rd = ref_map(m_pos);

    chk("rd_idx", 32'(bus.rd_idx_out), 32'(m_rd));
    chk("bootup", 32'(bootup_done_out), 32'(m_boot));
    chk("busy", 32'(busy_out), 32'(m_run && (m_pos < W0_N + L)));
    chk("sweep_done", 32'(sweep_done_out), 32'(m_run && (m_pos == W0_N + L)));
    if (exp_q.exists(cyc)) begin
      chk("q_valid", 32'(bus.q_valid_out), 32'd1);
      m_qc = exp_q[cyc];
      exp_q.delete(cyc);
    end else begin
      chk("q_valid", 32'(bus.q_valid_out), 32'd0);
    end
    chk("q_coeff", 32'(unsigned'(bus.q_coeff_out)), 32'(m_qc));
    if (exp_w0.exists(cyc)) begin
      chk("w0_valid", 32'(bus.w0_valid_out), 32'd1);
      chk("w0_idx", 32'(bus.w0_idx_out), 32'(exp_w0[cyc]));
      exp_w0.delete(cyc);
    end else begin
      chk("w0_valid", 32'(bus.w0_valid_out), 32'd0);
    end

    if (track) begin
      if (bootup_done_out === 1'b1 && first_boot < 0) first_boot = cyc;
      if (bus.q_valid_out === 1'b1 && first_q < 0) first_q = cyc;
      if (bus.w0_valid_out === 1'b1 && first_w0 < 0) first_w0 = cyc;
      if (sweep_done_out === 1'b1) done_seen = 1;
      if (done_seen && !gap_measured) begin
        if (busy_out === 1'b0) gap_obs++;
        else gap_measured = 1;
      end
    end

    reset         = rst;
    up_valid_in   = uv;
    freeze_in     = frz;
    gap_cycles_in = GAP_W'(gap);
    if (track && uv && up_cyc < 0) up_cyc = cyc;

    if (rst) begin
      exp_q.delete();
      exp_w0.delete();
      m_boot = 0; m_run = 0; m_pos = 0; m_rd = 0; m_qc = '0;
    end else begin
      if (issuing) begin
        exp_q[cyc + RD_LAT + 1] = wmem[ref_map(m_pos)];
        exp_w0[cyc + L]         = m_pos;
      end
      if (!m_run) begin
        if (m_boot && !frz) begin
          m_run = 1;
          m_pos = 0;
        end
      end else begin
        if (m_pos == W0_N + L - 1) begin
`ifdef W0_REFRESH_GAP_EN
          m_G = (gap < 1) ? 1 : gap;
`else
          m_G = 1;
`endif
        end
        if (m_pos >= W0_N + L && m_pos == W0_N + L + m_G - 1) begin
          if (frz) m_run = 0;
          else     m_pos = 0;
        end else begin
          m_pos++;
        end
      end
      if (uv) m_boot = 1;
    end
  endtask

  int exp_gap;
  bit frz_r;
  int gap_r;

  initial begin
    for (int i = 0; i < W_N; i++) wmem[i] = CW'($urandom);
`ifdef W0_REFRESH_GAP_EN
    exp_gap = 5;
`else
    exp_gap = 1;
`endif
    repeat (2) @(posedge clock);

    // Reset state, boot latency, first sweeps and gap length.
    track = 1;
    step(1, 0, 0, 5);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 5);
    step(0, 1, 0, 5);
    for (int i = 0; i < 200; i++) step(0, 0, 0, 5);
    track = 0;
    chk("boot_latency", 32'(first_boot - up_cyc), 32'd1);
    chk("first_q_latency", 32'(first_q - up_cyc), 32'd4);
    chk("first_w0_latency", 32'(first_w0 - up_cyc), 32'd5);
    chk("gap_len", 32'(gap_obs), 32'(exp_gap));

    // Freeze raised mid-sweep: sweep completes, then idles until released.
    for (int i = 0; i < 400 && !(m_run && m_pos == 20); i++) step(0, 0, 0, 5);
    chk("reach_k20", 32'(bus.rd_idx_out), 32'(ref_map(20)));
    for (int i = 0; i < 400 && m_run; i++) step(0, 0, 1, 5);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 5);
    chk("freeze_idle", 32'(busy_out), 32'd0);
    step(0, 0, 0, 5);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 5);

    // Reset mid-sweep, stay quiet, then reboot.
    for (int i = 0; i < 400 && !(m_run && m_pos == 30); i++) step(0, 0, 0, 3);
    chk("reach_k30", 32'(bus.rd_idx_out), 32'(ref_map(30)));
    step(1, 0, 0, 3);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 3);
    step(0, 1, 0, 3);
    for (int i = 0; i < 150; i++) step(0, 0, 0, 3);

    // Randomized traffic.
    frz_r = 0;
    gap_r = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) frz_r = ~frz_r;
      if ($urandom_range(99) == 0)  gap_r = int'($urandom_range(7));
      step(($urandom_range(799) == 0), ($urandom_range(49) == 0), frz_r, gap_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
